// File: rtl/seq_detect_sched.sv
// seq_detect_sched: a single "1101" serial detector shared round-robin among
// NCH requester channels. Each channel keeps its own 2-bit progress context.
// Optional per-channel saturating match counters are built when the macro
// SEQ_SCHED_CNT_EN is defined. Otherwise cnt_out is tied to zero.
module seq_detect_sched #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH-1:0]           req_bit,
  input  logic [NCH-1:0]           chan_en,
  output logic [NCH-1:0]           req_ready,
  output logic                     hit_valid,
  output logic [$clog2(NCH)-1:0]   hit_ch,
  input  logic [NCH-1:0]           cnt_clr,
  input  logic [$clog2(NCH)-1:0]   cnt_sel,
  output logic [CW-1:0]            cnt_out
);

  localparam int SW = $clog2(NCH);

  // Progress encodings: number of pattern bits matched so far.
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  logic [NCH-1:0][1:0] prog;
  logic [SW-1:0]       last_grant;
  logic [NCH-1:0]      cand;
  logic                gnt_any;
  logic [SW-1:0]       gnt_idx;
  logic                match;

  // Next-progress function for pattern 1101 with overlap (match -> P1).
  function automatic logic [1:0] nxt(input logic [1:0] p, input logic b);
    case (p)
      P0:      nxt = b ? P1 : P0;
      P1:      nxt = b ? P2 : P0;
      P2:      nxt = b ? P2 : P3;
      default: nxt = b ? P1 : P0;
    endcase
  endfunction

  // No channel is a candidate while reset is held, so nothing is consumed.
  assign cand = req_valid & chan_en & {NCH{~rst}};

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!gnt_any && cand[(int'(last_grant) + k) % NCH]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'((int'(last_grant) + k) % NCH);
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign match = gnt_any && (prog[gnt_idx] == P3) && req_bit[gnt_idx];

  // Context update: granted channel advances, disabled channels restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog       <= '0;
      last_grant <= SW'(NCH - 1);
      hit_valid  <= 1'b0;
      hit_ch     <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!chan_en[i])
          prog[i] <= P0;
        else if (gnt_any && gnt_idx == SW'(i))
          prog[i] <= nxt(prog[i], req_bit[i]);
      end
      if (gnt_any) last_grant <= gnt_idx;
      hit_valid <= match;
      if (match) hit_ch <= gnt_idx;
    end
  end

`ifdef SEQ_SCHED_CNT_EN
  logic [NCH-1:0][CW-1:0] cnt;

  // Saturating match counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr[i])
          cnt[i] <= '0;
        else if (match && gnt_idx == SW'(i) && cnt[i] != {CW{1'b1}})
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Readout mux; selects past NCH-1 (non power-of-two NCH) read zero.
  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < NCH) cnt_out = cnt[cnt_sel];
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr, cnt_sel};
  assign cnt_out    = '0;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched (NCH=4, CW=2). Stimulus pushes
// expected hits into a queue; a monitor pops them whenever hit_valid shows.
module tb_seq_detect_sched;

  localparam int NCH = 4;
  localparam int CW  = 2;
`ifdef SEQ_SCHED_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] req_valid = '0;
  logic [NCH-1:0] req_bit = '0;
  logic [NCH-1:0] chan_en = '1;
  logic [NCH-1:0] req_ready;
  logic           hit_valid;
  logic [1:0]     hit_ch;
  logic [NCH-1:0] cnt_clr = '0;
  logic [1:0]     cnt_sel = '0;
  logic [CW-1:0]  cnt_out;

  typedef struct { int cyc; int ch; } exp_t;
  exp_t q[$];
  int cyc   = 0;
  int vecs  = 0;
  int errs  = 0;

  seq_detect_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bit(req_bit),
    .chan_en(chan_en), .req_ready(req_ready), .hit_valid(hit_valid),
    .hit_ch(hit_ch), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every reported hit must match the head of the queue, and an
  // expected hit whose cycle has come without hit_valid is a miss.
  always @(negedge clk) begin
    if (hit_valid) begin
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL hit_unexpected: got hit_ch=%0d at cycle %0d, expected none", hit_ch, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(hit_ch) != e.ch || cyc != e.cyc) begin
          errs++;
          $display("FAIL hit: got ch=%0d cyc=%0d, expected ch=%0d cyc=%0d", hit_ch, cyc, e.ch, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      vecs++;
      errs++;
      $display("FAIL hit_missing: expected ch=%0d at cycle %0d, got none", q[0].ch, q[0].cyc);
      void'(q.pop_front());
    end
  end

  // One cycle of stimulus; checks req_ready and queues any expected hit.
  task automatic step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] en,
                      input logic r, input logic [3:0] clr, input logic [3:0] rdy,
                      input int hit);
    @(negedge clk);
    req_valid = v; req_bit = b; chan_en = en; rst = r; cnt_clr = clr;
    #1;
    vecs++;
    if (req_ready !== rdy) begin
      errs++;
      $display("FAIL req_ready: got %b, expected %b (cycle %0d)", req_ready, rdy, cyc);
    end
    if (hit >= 0) q.push_back('{cyc + 1, hit});
  endtask

  task automatic idle();
    step(4'h0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, -1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Send one bit on a single channel that is expected to be granted.
  task automatic send(input int ch, input logic b, input int hit);
    logic [3:0] m;
    m = 4'b0001 << ch;
    step(m, b ? m : 4'h0, 4'hF, 1'b0, 4'h0, m, hit);
  endtask

  initial begin
    int pat[4] = '{1, 1, 0, 1};
    int bits27[7] = '{1, 1, 0, 1, 1, 0, 1};

    // Reset: ready held low with a valid request present.
    step(4'h1, 4'h1, 4'hF, 1'b1, 4'h0, 4'h0, -1);
    step(4'h1, 4'h1, 4'hF, 1'b1, 4'h0, 4'h0, -1);
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_hit_ch", int'(hit_ch), 0);
    chk("rst_cnt_out", int'(cnt_out), 0);

    // Single channel 1101101: hits after the 4th and 7th bits.
    for (int i = 0; i < 7; i++)
      send(0, bits27[i][0], (i == 3 || i == 6) ? 0 : -1);
    idle(); idle();
    cnt_sel = 2'd0; #1;
    chk("cnt_ch0_after_two", int'(cnt_out), CNT ? 2 : 0);

    // Round-robin over four valid channels; ch0 and ch2 carry 1101.
    step(4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 4'h0, -1);
    for (int s = 0; s < 16; s++) begin
      logic b;
      b = pat[s / 4][0];
      step(4'hF, {1'b0, b, 1'b0, b}, 4'hF, 1'b0, 4'h0, 4'b0001 << (s % 4),
           (s == 12) ? 0 : (s == 14) ? 2 : -1);
    end
    idle(); idle();

    // Disable pulse on ch1 restarts its context: 110, off, 1 -> no hit.
    step(4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 4'h0, -1);
    send(1, 1'b1, -1); send(1, 1'b1, -1); send(1, 1'b0, -1);
    step(4'b0010, 4'b0010, 4'b1101, 1'b0, 4'h0, 4'h0, -1);
    send(1, 1'b1, -1);
    send(1, 1'b1, -1); send(1, 1'b0, -1); send(1, 1'b1, 1);
    idle(); idle();

    // Reset pulse mid-pattern on ch3; then ch0 gets first grant.
    send(3, 1'b1, -1); send(3, 1'b1, -1); send(3, 1'b0, -1);
    step(4'b1000, 4'b1000, 4'hF, 1'b1, 4'h0, 4'h0, -1);
    step(4'hF, 4'b1000, 4'hF, 1'b0, 4'h0, 4'b0001, -1);
    send(3, 1'b1, -1);
    idle(); idle();

    // Counter saturation (CW=2) and clear-wins-over-increment.
    step(4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 4'h0, -1);
    cnt_sel = 2'd0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 4; i++) send(0, pat[i][0], (i == 3) ? 0 : -1);
      if (g == 1) begin
        idle(); #1;
        chk("cnt_two_matches", int'(cnt_out), CNT ? 2 : 0);
      end
    end
    idle(); #1;
    chk("cnt_saturated", int'(cnt_out), CNT ? 3 : 0);
    cnt_sel = 2'd1; #1;
    chk("cnt_sel_ch1", int'(cnt_out), 0);
    cnt_sel = 2'd0;
    send(0, 1'b1, -1); send(0, 1'b1, -1); send(0, 1'b0, -1);
    step(4'h1, 4'h1, 4'hF, 1'b0, 4'h1, 4'h1, 0);
    idle(); #1;
    chk("cnt_clear_wins", int'(cnt_out), 0);

    idle(); idle(); idle();
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
SEQ_DETECT_SCHED -- requirements
Module: seq_detect_sched

Interface
REQ-001 Parameter NCH, default 4: number of requester channels (2..8).
REQ-002 Parameter CW, default 8: width of each per-channel match counter.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NCH  channel i presents a serial bit.
REQ-006 req_bit  input  NCH  serial bit of channel i, qualified by req_valid[i].
REQ-007 chan_en  input  NCH  channel enable mask.
REQ-008 req_ready  output  NCH  one-hot grant; bit i is consumed when req_valid[i] and req_ready[i] are both high.
REQ-009 hit_valid  output  1  registered one-cycle pulse reporting a pattern match.
REQ-010 hit_ch  output  clog2(NCH)  channel index of the match, valid with hit_valid.
REQ-011 cnt_clr  input  NCH  synchronous clear of channel i's match counter.
REQ-012 cnt_sel  input  clog2(NCH)  counter readout select.
REQ-013 cnt_out  output  CW  combinational readout of the selected channel's counter.

Function
REQ-014 The block SHALL share one serial detector for pattern 1101 (first bit first) among NCH channels, keeping a separate 2-bit progress context per channel.
- Arbitration: each cycle at most one channel is granted.
- Candidates: channels with req_valid=1 and chan_en=1.
REQ-015 req_ready SHALL be combinational in the same cycle and one-hot or zero; it SHALL be zero when no candidate exists.
REQ-016 Grant order SHALL be round-robin: the search starts at last_grant+1 modulo NCH; last_grant updates only on a cycle with a grant.
REQ-017 The granted channel's progress SHALL update as follows (progress = number of pattern bits matched):
- p0: bit 1 -> p1; bit 0 -> p0.
- p1: bit 1 -> p2; bit 0 -> p0.
- p2: bit 0 -> p3; bit 1 -> p2.
- p3: bit 1 -> match, then p1 (overlap); bit 0 -> p0.
REQ-018 A match SHALL assert hit_valid with hit_ch = granted index in the cycle after the grant; otherwise hit_valid = 0 (latency 1).
REQ-019 The progress of ungranted channels SHALL hold unchanged; interleaving channels SHALL NOT corrupt each other's context.
REQ-020 A channel with chan_en=0 SHALL never be granted, and its progress SHALL be forced to p0 every cycle.
REQ-021 Re-enabling a channel SHALL therefore restart its detection from p0.

Reset
REQ-022 On rst=1 the block SHALL set:
- all progress contexts to p0;
- last_grant to NCH-1, so channel 0 has first priority;
- hit_valid to 0 and hit_ch to 0;
- all counters to 0.
REQ-023 While rst=1, req_ready SHALL be 0 and no bit SHALL be consumed.
REQ-024 Reset asserted mid-pattern SHALL discard all partial matches, and any match pending from the grant cycle SHALL NOT be reported.

Configuration
REQ-025 Macro SEQ_SCHED_CNT_EN defined:
- Each channel has a CW-bit match counter that increments on each of its matches and saturates at 2^CW-1.
- cnt_clr[i] zeroes counter i and wins over a simultaneous increment.
- cnt_out = counter[cnt_sel].
REQ-026 Macro SEQ_SCHED_CNT_EN undefined: no counters are built, cnt_clr and cnt_sel are ignored, and cnt_out SHALL be constant 0.

Verification
REQ-027 Single channel: ch0 bits 1,1,0,1,1,0,1 -> hit_valid pulses (hit_ch=0) one cycle after the 4th and 7th bits; cnt_out(sel 0)=2.
REQ-028 All four channels valid, each channel sends one bit per round -> req_ready order 0,1,2,3,0,...; streams ch0=1101 and ch2=1101 interleaved -> hits on ch0 then ch2.
REQ-029 Channel 1 sends 1,1,0; chan_en[1] drops for 1 cycle and is restored; then sends 1 -> no hit.
REQ-030 Channel 3 sends 1,1,0, then rst pulses for 1 cycle, then sends 1 -> no hit; req_ready=0 during rst; the next grant goes to channel 0 if valid.
REQ-031 (CNT_EN, CW=2) Channel 0 sends 1101 five times -> counter saturates at 3; cnt_clr[0] in the same cycle as the next match -> counter reads 0.
